// File: rtl/irq_pending_ctrl.sv
// Interrupt-request front end: synchronises and edge-detects request lines into a
// pending register, presents the masked vector to an external priority encoder and
// runs the irq/ack handshake with the service side.
module irq_pending_ctrl #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    output logic [N-1:0]    pend_o,
    input  logic [IDXW-1:0] enc_y_i,
    input  logic            enc_idle_i,
    output logic            irq_o,
    output logic [IDXW-1:0] irq_id_o,
    input  logic            ack_i,
    output logic            overrun_o,
    output logic [1:0]      dbg_state
);

    // Handshake: irq_o stays high with a stable irq_id_o until ack_i is seen high on
    // a rising clk edge; the serviced pending bit clears on that same edge, irq_o
    // drops, and the next irq_o cannot rise before the second edge after the ack.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    sync_s1;
    logic [N-1:0]    sync_s2;
    logic [N-1:0]    sync_s3;
    logic [N-1:0]    edges;
    logic [N-1:0]    pending;
    logic [N-1:0]    pending_next;
    logic [N-1:0]    clr;
    logic            irq_next;
    logic [IDXW-1:0] id_next;
    logic            overrun_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= req_i;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    assign edges = sync_s2 & ~sync_s3;

    always_comb begin
        state_next = state;
        irq_next   = irq_o;
        id_next    = irq_id_o;
        clr        = '0;
        case (state)
            ST_IDLE: begin
                if (!enc_idle_i) begin
                    state_next = ST_ISSUE;
                    irq_next   = 1'b1;
                    id_next    = enc_y_i;
                end
            end
            ST_ISSUE: begin
                if (ack_i) begin
                    clr[irq_id_o] = 1'b1;
                    irq_next      = 1'b0;
                    state_next    = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                irq_next   = 1'b0;
            end
        endcase
    end

    // A fresh edge beats a same-cycle clear, so a re-request during ack is kept.
    assign pending_next = (pending & ~clr) | edges;
    assign overrun_next = |(edges & pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            overrun_o <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            irq_o     <= irq_next;
            irq_id_o  <= id_next;
            overrun_o <= overrun_next;
        end
    end

    assign pend_o    = pending & mask_i;
    assign dbg_state = state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a behavioural 8x3 priority encoder
// closing the pend_o -> enc_y_i/enc_idle_i loop.
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic [7:0] pend;
    logic [2:0] enc_y;
    logic       enc_idle;
    logic       irq;
    logic [2:0] irq_id;
    logic       ack;
    logic       overrun;
    logic [1:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [2:0] exp_q[$];

    irq_pending_ctrl #(.N(8), .IDXW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .mask_i     (mask),
        .pend_o     (pend),
        .enc_y_i    (enc_y),
        .enc_idle_i (enc_idle),
        .irq_o      (irq),
        .irq_id_o   (irq_id),
        .ack_i      (ack),
        .overrun_o  (overrun),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference priority encoder: highest set bit wins
    always_comb begin
        enc_y = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pend[i]) enc_y = i[2:0];
        enc_idle = (pend == 8'h00);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        mask  = 8'hFF;
        ack   = 1'b0;

        // 1 Reset
        tick(3);
        check_eq("rst_pend", pend, 8'h00);
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_ovr", overrun, 1'b0);
        check_eq("rst_state", dbg_state, 2'd0);
        req = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check_eq("rel_pend", pend, 8'h00);
        check_eq("rel_irq", irq, 1'b0);

        // 2 Single request, latency and ack
        req = 8'h04;
        tick(2);
        check_eq("single_e2_pend", pend, 8'h00);
        tick(1);
        check_eq("single_e3_pend", pend, 8'h04);
        check_eq("single_e3_irq", irq, 1'b0);
        tick(1);
        check_eq("single_e4_irq", irq, 1'b1);
        check_eq("single_id", irq_id, 3'd2);
        check_eq("single_state", dbg_state, 2'd1);
        do_ack();
        check_eq("single_ack_pend", pend, 8'h00);
        check_eq("single_ack_irq", irq, 1'b0);
        check_eq("single_gap_state", dbg_state, 2'd2);
        tick(3);
        check_eq("single_idle_irq", irq, 1'b0);
        check_eq("single_idle_state", dbg_state, 2'd0);
        req = 8'h00;
        tick(4);

        // 3 Priority ordering with 2-cycle gaps
        exp_q = '{3'd5, 3'd2, 3'd0};
        req = 8'h25;
        tick(3);
        check_eq("prio_pend", pend, 8'h25);
        tick(1);
        while (exp_q.size() > 0) begin
            logic [2:0] exp_id;
            exp_id = exp_q.pop_front();
            check_eq("prio_irq", irq, 1'b1);
            check_eq("prio_id", irq_id, exp_id);
            do_ack();
            check_eq("prio_ack_irq", irq, 1'b0);
            if (exp_q.size() > 0) begin
                tick(1);
                check_eq("prio_gap_irq", irq, 1'b0);
                tick(1);
            end
        end
        check_eq("prio_done_pend", pend, 8'h00);
        tick(2);
        check_eq("prio_done_irq", irq, 1'b0);
        req = 8'h00;
        tick(4);

        // 4 Masked line stays pending, presented when unmasked
        mask = 8'h7F;
        req  = 8'h80;
        tick(3);
        check_eq("mask_pend", pend, 8'h00);
        tick(3);
        check_eq("mask_irq", irq, 1'b0);
        mask = 8'hFF;
        #1;
        check_eq("unmask_pend", pend, 8'h80);
        tick(1);
        check_eq("unmask_irq", irq, 1'b1);
        check_eq("unmask_id", irq_id, 3'd7);
        do_ack();
        check_eq("unmask_ack_pend", pend, 8'h00);
        req = 8'h00;
        tick(4);

        // 5 Overrun, then set-wins on the ack cycle
        req = 8'h08;
        tick(3);
        check_eq("ovr_first_pend", pend, 8'h08);
        check_eq("ovr_first_ovr", overrun, 1'b0);
        tick(1);
        check_eq("ovr_irq", irq, 1'b1);
        check_eq("ovr_id", irq_id, 3'd3);
        req = 8'h00;
        tick(4);
        req = 8'h08;
        tick(2);
        check_eq("ovr_pre", overrun, 1'b0);
        tick(1);
        check_eq("ovr_pulse", overrun, 1'b1);
        check_eq("ovr_pend", pend, 8'h08);
        tick(1);
        check_eq("ovr_post", overrun, 1'b0);
        check_eq("ovr_irq_held", irq, 1'b1);
        req = 8'h00;
        tick(4);
        req = 8'h08;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_eq("setwins_irq", irq, 1'b0);
        check_eq("setwins_pend", pend, 8'h08);
        check_eq("setwins_ovr", overrun, 1'b0);
        tick(1);
        check_eq("setwins_gap_irq", irq, 1'b0);
        tick(1);
        check_eq("setwins_reissue", irq, 1'b1);
        check_eq("setwins_id", irq_id, 3'd3);

        // 6 Asynchronous reset mid-handshake
        rst_n = 1'b0;
        #1;
        check_eq("arst_irq", irq, 1'b0);
        check_eq("arst_pend", pend, 8'h00);
        check_eq("arst_state", dbg_state, 2'd0);
        req = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_eq("arst_rel_irq", irq, 1'b0);
        check_eq("arst_rel_pend", pend, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
